dotl_multi: RTL and testbench
=============================

Name: dotl_multi

Overview:
- Parametrised next-generation dice / traffic-light controller.
- Contains a wrapping dice counter with a programmable face count and a traffic-light FSM with per-phase hold durations.
- A 2-bit mode selector chooses which engine drives a registered result bus; blank and lamp-test modes are added.
- Sits between the board buttons/switches and the 3-LED display, and replaces the single-bit-select generation.

Parameters:
- DICE_MAX, 6, number of dice faces; counter range is 1..DICE_MAX; legal range 2..7.
- RED_CYC, 4, clock cycles spent in RED; must be ≥1.
- RED_AMB_CYC, 1, clock cycles spent in RED_AMBER; must be ≥1.
- GREEN_CYC, 4, clock cycles spent in GREEN; must be ≥1.
- AMBER_CYC, 1, clock cycles spent in AMBER; must be ≥1.
- TMR_W, 8, phase timer width; every *_CYC value must be ≤ 2^TMR_W.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- button  input  1  dice roll request; level-sensitive.
- mode  input  2  display mode: 00 dice, 01 traffic, 10 blank, 11 lamp test.
- result  output  3  registered display value; traffic encoding is {red, amber, green}.
- roll_done  output  1  one-cycle pulse, registered, marking the end of a roll.

Behaviour:
- Reset (rst=1 at an edge) sets:
  - dice_cnt=1
  - tl_state=RED, tl_tmr=0
  - result=3'b000
  - roll_done=0
  - btn_q=0
- Reset is honoured mid-roll and mid-phase; there is no partial state afterwards.
- Dice engine:
  - Runs irrespective of mode.
  - Each edge with button=1: dice_cnt <= (dice_cnt==DICE_MAX) ? 1 : dice_cnt+1.
  - With button=0: dice_cnt holds.
- Roll-done pulse:
  - btn_q registers button.
  - roll_done is registered high for exactly one cycle after an edge where btn_q=1 and button=0.
  - Back-to-back presses give one pulse per falling edge.
- Traffic FSM:
  - States in order: RED → RED_AMBER → GREEN → AMBER → RED.
  - Advances only while mode==01; in other modes state and timer freeze.
  - tl_tmr counts 0..PHASE_CYC-1. At PHASE_CYC-1 the FSM moves to the next state and clears tl_tmr in the same edge.
  - A *_CYC value of 1 gives a single-cycle phase.
- Result register, updated every edge from pre-edge state:
  - mode 00: result = dice_cnt (binary 1..DICE_MAX)
  - mode 01: RED=100, RED_AMBER=110, GREEN=001, AMBER=010
  - mode 10: result = 000
  - mode 11: result = 111
- Latency is 1 cycle from state or mode change to result.
- Mode switching:
  - Takes effect on the next edge; no glitch, no reset of either engine.
  - Returning to 01 resumes the FSM at the frozen state and timer value.
- Dice value 0 and values above DICE_MAX are unreachable.
- Out-of-range parameters must trigger an elaboration-time $error.

Optional Feature:
- Macro: DOTL_DEBOUNCE_EN.
- Defined:
  - button passes through a 2-flop synchroniser.
  - A 3-bit stability counter follows; the internal button_db changes only after 4 consecutive identical synchronised samples.
  - button_db drives both the dice engine and roll_done, adding 6 cycles of input latency.
- Undefined: button is used raw, as described in Behaviour. This is the default, and all test plan values assume it.

Decomposition:
- Package dotl_pkg holds:
  - typedef tl_state_t, a 2-bit enum {RED, RED_AMBER, GREEN, AMBER}
  - localparam light encodings LT_RED=3'b100, LT_RED_AMB=3'b110, LT_GREEN=3'b001, LT_AMBER=3'b010
  - mode codes MODE_DICE=2'b00, MODE_TL=2'b01, MODE_BLANK=2'b10, MODE_TEST=2'b11
- Sub-module dotl_tl_fsm holds the traffic FSM plus phase timer, with ports clk, rst, en, state.
- The dice counter, roll_done logic and output mux stay in the top module.

Test Plan:
- Reset with mode=00, then button=1 for 10 edges, then button=0 → result settles to 5 and holds; roll_done pulses once, exactly 1 cycle after button falls.
- DICE_MAX=6, button held 12 edges from reset → dice_cnt sequence 2,3,4,5,6,1,2,3,4,5,6,1; result never shows 0 or 7.
- mode=01 from reset, default timings → after the reset edge result reads 100 for 4 cycles, 110 for 1, 001 for 4, 010 for 1, then 100 again; period is 10 cycles.
- mode=01 for 6 cycles, then mode=00 for 20 cycles, then mode=01 → result resumes GREEN (001) for the remaining 3 cycles; the FSM did not advance while frozen.
- mode=10 → result=000; mode=11 → result=111; each appears 1 cycle after the mode change, whatever the engine state.
- rst=1 asserted mid-GREEN while button=1 → next edge gives result=000, roll_done=0; after release with mode=01, RED (100) is held for a full 4 cycles.

Source files
------------

// File: rtl/dotl_pkg.sv
// Shared types and constants for the dice / traffic-light display controller.
// Provides the traffic-light state enum, the lamp encodings and the mode codes.
package dotl_pkg;

    typedef enum logic [1:0] {
        RED       = 2'd0,
        RED_AMBER = 2'd1,
        GREEN     = 2'd2,
        AMBER     = 2'd3
    } tl_state_t;

    // Lamp encodings are {red, amber, green}
    localparam logic [2:0] LT_RED     = 3'b100;
    localparam logic [2:0] LT_RED_AMB = 3'b110;
    localparam logic [2:0] LT_GREEN   = 3'b001;
    localparam logic [2:0] LT_AMBER   = 3'b010;

    localparam logic [1:0] MODE_DICE  = 2'b00;
    localparam logic [1:0] MODE_TL    = 2'b01;
    localparam logic [1:0] MODE_BLANK = 2'b10;
    localparam logic [1:0] MODE_TEST  = 2'b11;

endpackage

// File: rtl/dotl_tl_fsm.sv
// Traffic-light sequencer: RED -> RED_AMBER -> GREEN -> AMBER -> RED with a
// per-phase hold timer. State and timer freeze whenever en is low.
module dotl_tl_fsm
    import dotl_pkg::*;
#(
    parameter int RED_CYC     = 4,
    parameter int RED_AMB_CYC = 1,
    parameter int GREEN_CYC   = 4,
    parameter int AMBER_CYC   = 1,
    parameter int TMR_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [1:0] state
);

    localparam logic [TMR_W-1:0] RED_LAST     = TMR_W'(RED_CYC - 1);
    localparam logic [TMR_W-1:0] RED_AMB_LAST = TMR_W'(RED_AMB_CYC - 1);
    localparam logic [TMR_W-1:0] GREEN_LAST   = TMR_W'(GREEN_CYC - 1);
    localparam logic [TMR_W-1:0] AMBER_LAST   = TMR_W'(AMBER_CYC - 1);

    tl_state_t        state_reg;
    tl_state_t        state_next;
    logic [TMR_W-1:0] tmr_reg;
    logic [TMR_W-1:0] tmr_last;

    always_comb begin
        state_next = RED;
        tmr_last   = RED_LAST;
        case (state_reg)
            RED:       begin state_next = RED_AMBER; tmr_last = RED_LAST;     end
            RED_AMBER: begin state_next = GREEN;     tmr_last = RED_AMB_LAST; end
            GREEN:     begin state_next = AMBER;     tmr_last = GREEN_LAST;   end
            AMBER:     begin state_next = RED;       tmr_last = AMBER_LAST;   end
        endcase
    end

    // The last count of a phase both advances the state and clears the timer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RED;
            tmr_reg   <= '0;
        end else if (en) begin
            if (tmr_reg == tmr_last) begin
                state_reg <= state_next;
                tmr_reg   <= '0;
            end else begin
                tmr_reg <= tmr_reg + 1'b1;
            end
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/dotl_multi.sv
// Dice / traffic-light display controller: wrapping dice counter, roll-done pulse,
// traffic FSM and a mode-selected registered result. Optional macro: DOTL_DEBOUNCE_EN.
module dotl_multi
    import dotl_pkg::*;
#(
    parameter int DICE_MAX    = 6,
    parameter int RED_CYC     = 4,
    parameter int RED_AMB_CYC = 1,
    parameter int GREEN_CYC   = 4,
    parameter int AMBER_CYC   = 1,
    parameter int TMR_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    input  logic [1:0] mode,
    output logic [2:0] result,
    output logic       roll_done
);

    generate
        if (DICE_MAX < 2 || DICE_MAX > 7) begin : g_bad_dice
            $error("dotl_multi: DICE_MAX must be in 2..7");
        end
        if (RED_CYC < 1 || RED_AMB_CYC < 1 || GREEN_CYC < 1 || AMBER_CYC < 1) begin : g_bad_cyc
            $error("dotl_multi: every phase duration must be at least 1");
        end
        if (TMR_W < 1 || TMR_W > 30) begin : g_bad_tmr_w
            $error("dotl_multi: TMR_W must be in 1..30");
        end else if (RED_CYC > (1 << TMR_W) || RED_AMB_CYC > (1 << TMR_W) ||
                     GREEN_CYC > (1 << TMR_W) || AMBER_CYC > (1 << TMR_W)) begin : g_bad_tmr
            $error("dotl_multi: a phase duration exceeds the timer range");
        end
    endgenerate

    localparam logic [2:0] DICE_TOP = 3'(DICE_MAX);

    logic button_db;

`ifdef DOTL_DEBOUNCE_EN
    logic       sync1_reg;
    logic       sync2_reg;
    logic       db_reg;
    logic [2:0] stab_cnt_reg;

    // The debounced level flips only after 4 consecutive differing synchronised samples
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg    <= 1'b0;
            sync2_reg    <= 1'b0;
            db_reg       <= 1'b0;
            stab_cnt_reg <= 3'd0;
        end else begin
            sync1_reg <= button;
            sync2_reg <= sync1_reg;
            if (sync2_reg == db_reg) begin
                stab_cnt_reg <= 3'd0;
            end else if (stab_cnt_reg == 3'd3) begin
                db_reg       <= sync2_reg;
                stab_cnt_reg <= 3'd0;
            end else begin
                stab_cnt_reg <= stab_cnt_reg + 3'd1;
            end
        end
    end

    assign button_db = db_reg;
`else
    assign button_db = button;
`endif

    logic [2:0] dice_cnt_reg;
    logic       btn_q_reg;
    logic       roll_done_reg;
    logic [2:0] result_reg;
    logic [2:0] result_next;
    logic [1:0] tl_state;

    dotl_tl_fsm #(
        .RED_CYC     (RED_CYC),
        .RED_AMB_CYC (RED_AMB_CYC),
        .GREEN_CYC   (GREEN_CYC),
        .AMBER_CYC   (AMBER_CYC),
        .TMR_W       (TMR_W)
    ) u_tl_fsm (
        .clk   (clk),
        .rst   (rst),
        .en    (mode == MODE_TL),
        .state (tl_state)
    );

    always_comb begin
        result_next = 3'b000;
        case (mode)
            MODE_DICE: result_next = dice_cnt_reg;
            MODE_TL: begin
                case (tl_state_t'(tl_state))
                    RED:       result_next = LT_RED;
                    RED_AMBER: result_next = LT_RED_AMB;
                    GREEN:     result_next = LT_GREEN;
                    AMBER:     result_next = LT_AMBER;
                endcase
            end
            MODE_BLANK: result_next = 3'b000;
            MODE_TEST:  result_next = 3'b111;
        endcase
    end

    // Dice engine runs regardless of mode so switching never disturbs a roll
    always_ff @(posedge clk) begin
        if (rst) begin
            dice_cnt_reg  <= 3'd1;
            btn_q_reg     <= 1'b0;
            roll_done_reg <= 1'b0;
            result_reg    <= 3'b000;
        end else begin
            if (button_db) begin
                dice_cnt_reg <= (dice_cnt_reg == DICE_TOP) ? 3'd1 : dice_cnt_reg + 3'd1;
            end
            btn_q_reg     <= button_db;
            roll_done_reg <= btn_q_reg & ~button_db;
            result_reg    <= result_next;
        end
    end

    assign result    = result_reg;
    assign roll_done = roll_done_reg;

endmodule

// File: tb/tb_dotl_multi.sv
// Self-checking bench for dotl_multi: directed scenarios followed by random
// button/mode/reset traffic, all compared against a behavioural model.
module tb_dotl_multi;

    localparam int DICE_MAX    = 6;
    localparam int RED_CYC     = 4;
    localparam int RED_AMB_CYC = 1;
    localparam int GREEN_CYC   = 4;
    localparam int AMBER_CYC   = 1;
    localparam int TMR_W       = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       button = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [2:0] result;
    logic       roll_done;

    int asserts_n = 0;
    int fails_n   = 0;
    int step_n    = 0;

    // Behavioural model: dice face, phase index with elapsed cycles, previous button
    int         m_dice  = 1;
    int         m_phase = 0;
    int         m_elap  = 0;
    logic       m_btnq  = 1'b0;
    int         dur[4]  = '{RED_CYC, RED_AMB_CYC, GREEN_CYC, AMBER_CYC};
    logic [2:0] lamp[4] = '{3'b100, 3'b110, 3'b001, 3'b010};

    dotl_multi #(
        .DICE_MAX    (DICE_MAX),
        .RED_CYC     (RED_CYC),
        .RED_AMB_CYC (RED_AMB_CYC),
        .GREEN_CYC   (GREEN_CYC),
        .AMBER_CYC   (AMBER_CYC),
        .TMR_W       (TMR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .button    (button),
        .mode      (mode),
        .result    (result),
        .roll_done (roll_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        asserts_n++;
        assert (obs === exp)
        else begin
            fails_n++;
            $error("FAIL %s step %0d: observed %b expected %b", tag, step_n, obs, exp);
        end
    endtask

    task automatic step(input logic b, input logic [1:0] m, input logic r);
        logic [2:0] exp_res;
        logic       exp_rd;
        button = b;
        mode   = m;
        rst    = r;
        if (r) begin
            exp_res = 3'b000;
            exp_rd  = 1'b0;
            m_dice  = 1;
            m_phase = 0;
            m_elap  = 0;
            m_btnq  = 1'b0;
        end else begin
            case (m)
                2'b00:   exp_res = 3'(m_dice);
                2'b01:   exp_res = lamp[m_phase];
                2'b10:   exp_res = 3'b000;
                default: exp_res = 3'b111;
            endcase
            exp_rd = m_btnq && !b;
            if (b) m_dice = (m_dice % DICE_MAX) + 1;
            m_btnq = b;
            if (m == 2'b01) begin
                m_elap++;
                if (m_elap == dur[m_phase]) begin
                    m_phase = (m_phase + 1) % 4;
                    m_elap  = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        step_n++;
        check("result", result, exp_res);
        check("roll_done", {2'b00, roll_done}, {2'b00, exp_rd});
    endtask

    initial begin
        logic       rb;
        logic [1:0] rm;
        logic       rr;

        // Dice: ten presses from reset land on 5, one roll_done after release
        step(1'b0, 2'b00, 1'b1);
        repeat (10) step(1'b1, 2'b00, 1'b0);
        repeat (5) step(1'b0, 2'b00, 1'b0);

        // Full wrap over twelve presses
        step(1'b0, 2'b00, 1'b1);
        repeat (12) step(1'b1, 2'b00, 1'b0);
        repeat (2) step(1'b0, 2'b00, 1'b0);

        // Traffic sequence over two periods
        step(1'b0, 2'b01, 1'b1);
        repeat (21) step(1'b0, 2'b01, 1'b0);

        // Freeze in GREEN then resume
        step(1'b0, 2'b01, 1'b1);
        repeat (6) step(1'b0, 2'b01, 1'b0);
        repeat (20) step(1'b0, 2'b00, 1'b0);
        repeat (6) step(1'b0, 2'b01, 1'b0);

        // Blank and lamp test
        repeat (2) step(1'b0, 2'b10, 1'b0);
        repeat (2) step(1'b0, 2'b11, 1'b0);
        step(1'b1, 2'b10, 1'b0);
        step(1'b0, 2'b11, 1'b0);

        // Reset mid-GREEN with button held
        step(1'b0, 2'b01, 1'b1);
        repeat (6) step(1'b1, 2'b01, 1'b0);
        step(1'b1, 2'b01, 1'b1);
        repeat (12) step(1'b0, 2'b01, 1'b0);

        // Random traffic with sticky mode and occasional reset
        rm = 2'b00;
        rb = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) rm = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) rb = ~rb;
            rr = ($urandom_range(0, 59) == 0);
            step(rb, rm, rr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts_n, fails_n);
        $finish;
    end

endmodule
